// File: rtl/map_write_arbiter.sv
// map_write_arbiter: shares the single tile-map write port between buffered
// host writes, the engine req/grant port and the full-map clear sweeper.
// Optional build macro MAP_ARB_STATS_EN adds a saturating dropped-write counter.
module map_write_arbiter #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 8,
  parameter int MAP_SIZE        = 256,
  parameter int HOST_FIFO_DEPTH = 4
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic                                 HOST_WE,
  input  logic [ADDR_W-1:0]                    HOST_ADDR,
  input  logic [DATA_W-1:0]                    HOST_DATA,
  input  logic                                 ENG_REQ,
  input  logic [ADDR_W-1:0]                    ENG_ADDR,
  input  logic [DATA_W-1:0]                    ENG_DATA,
  output logic                                 ENG_GNT,
  input  logic                                 CLR_START,
  input  logic [DATA_W-1:0]                    CLR_DATA,
  output logic                                 CLR_BUSY,
  input  logic                                 OVF_CLR,
  output logic                                 HOST_OVF,
  output logic [$clog2(HOST_FIFO_DEPTH):0]     FIFO_LEVEL,
  output logic [15:0]                          DROP_CNT,
  output logic                                 MAP_WE,
  output logic [ADDR_W-1:0]                    MAP_ADDR,
  output logic [DATA_W-1:0]                    MAP_DATA
);
  localparam int PTR_W = $clog2(HOST_FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = ADDR_W + 1;  // one spare bit so MAP_SIZE == 2**ADDR_W never wraps

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_t                      state_q, state_d;
  wr_t [HOST_FIFO_DEPTH-1:0]   fifo_mem_q, fifo_mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]            level_q, level_d;
  logic                        last_eng_q, last_eng_d;
  logic                        eng_gnt_q, eng_gnt_d;
  logic                        map_we_q, map_we_d;
  logic [ADDR_W-1:0]           map_addr_q, map_addr_d;
  logic [DATA_W-1:0]           map_data_q, map_data_d;
  logic                        clr_busy_q, clr_busy_d;
  logic [CNT_W-1:0]            clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]           fill_q, fill_d;
  logic                        ovf_q, ovf_d;

  logic host_vld, eng_vld, full, pop, push, drop;

  // Arbitration, clear sweep and host FIFO bookkeeping for the next edge.
  always_comb begin
    state_d    = state_q;
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_eng_d = last_eng_q;
    eng_gnt_d  = 1'b0;
    map_we_d   = 1'b0;
    map_addr_d = map_addr_q;
    map_data_d = map_data_q;
    clr_busy_d = clr_busy_q;
    clr_cnt_d  = clr_cnt_q;
    fill_d     = fill_q;
    pop        = 1'b0;

    host_vld = (level_q != '0);
    // The engine still holds REQ during its grant cycle; ignore it there.
    eng_vld  = ENG_REQ && !eng_gnt_q;

    case (state_q)
      IDLE: begin
        if (CLR_START) begin
          state_d    = CLEAR;
          fill_d     = CLR_DATA;
          clr_cnt_d  = '0;
          clr_busy_d = 1'b1;
        end else if (host_vld && (!eng_vld || last_eng_q)) begin
          pop        = 1'b1;
          map_we_d   = 1'b1;
          map_addr_d = fifo_mem_q[rd_ptr_q].addr;
          map_data_d = fifo_mem_q[rd_ptr_q].data;
          last_eng_d = 1'b0;
        end else if (eng_vld) begin
          eng_gnt_d  = 1'b1;
          map_we_d   = 1'b1;
          map_addr_d = ENG_ADDR;
          map_data_d = ENG_DATA;
          last_eng_d = 1'b1;
        end
      end
      CLEAR: begin
        map_we_d   = 1'b1;
        map_addr_d = clr_cnt_q[ADDR_W-1:0];
        map_data_d = fill_q;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CNT_W'(MAP_SIZE - 1)) begin
          state_d    = IDLE;
          clr_busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop on the same edge frees the slot a full-FIFO push needs.
    full = (level_q == LVL_W'(HOST_FIFO_DEPTH));
    push = HOST_WE && (!full || pop);
    drop = HOST_WE && full && !pop;

    if (push) begin
      fifo_mem_d[wr_ptr_q] = '{addr: HOST_ADDR, data: HOST_DATA};
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};

    // Sticky overflow; a new drop beats a simultaneous clear.
    ovf_d = drop ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);
  end

  // Control and output registers; reset also empties the FIFO and aborts a clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_eng_q <= 1'b1;
      eng_gnt_q  <= 1'b0;
      map_we_q   <= 1'b0;
      map_addr_q <= '0;
      map_data_q <= '0;
      clr_busy_q <= 1'b0;
      clr_cnt_q  <= '0;
      fill_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      last_eng_q <= last_eng_d;
      eng_gnt_q  <= eng_gnt_d;
      map_we_q   <= map_we_d;
      map_addr_q <= map_addr_d;
      map_data_q <= map_data_d;
      clr_busy_q <= clr_busy_d;
      clr_cnt_q  <= clr_cnt_d;
      fill_q     <= fill_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    fifo_mem_q <= fifo_mem_d;
  end

`ifdef MAP_ARB_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; OVF_CLR restarts it, counting a coincident drop.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (OVF_CLR)                        drop_cnt_d = {15'd0, drop};
    else if (drop && drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge CLK) begin
    if (RESET) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign DROP_CNT = drop_cnt_q;
`else
  assign DROP_CNT = '0;
`endif

  assign ENG_GNT    = eng_gnt_q;
  assign CLR_BUSY   = clr_busy_q;
  assign HOST_OVF   = ovf_q;
  assign FIFO_LEVEL = level_q;
  assign MAP_WE     = map_we_q;
  assign MAP_ADDR   = map_addr_q;
  assign MAP_DATA   = map_data_q;
endmodule

// File: tb/tb_map_write_arbiter.sv
// Self-checking bench for map_write_arbiter: directed scenarios plus random
// traffic, all compared each cycle against a queue-based reference model.
module tb_map_write_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAP_SIZE = 256;
`ifdef MAP_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, HOST_WE, ENG_REQ, CLR_START, OVF_CLR;
  logic [7:0]  HOST_ADDR, HOST_DATA, ENG_ADDR, ENG_DATA, CLR_DATA;
  logic        ENG_GNT, CLR_BUSY, HOST_OVF, MAP_WE;
  logic [2:0]  FIFO_LEVEL;
  logic [15:0] DROP_CNT;
  logic [7:0]  MAP_ADDR, MAP_DATA;

  map_write_arbiter #(.ADDR_W(8), .DATA_W(8), .MAP_SIZE(MAP_SIZE), .HOST_FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR), .HOST_DATA(HOST_DATA),
    .ENG_REQ(ENG_REQ), .ENG_ADDR(ENG_ADDR), .ENG_DATA(ENG_DATA), .ENG_GNT(ENG_GNT),
    .CLR_START(CLR_START), .CLR_DATA(CLR_DATA), .CLR_BUSY(CLR_BUSY), .OVF_CLR(OVF_CLR),
    .HOST_OVF(HOST_OVF), .FIFO_LEVEL(FIFO_LEVEL), .DROP_CNT(DROP_CNT),
    .MAP_WE(MAP_WE), .MAP_ADDR(MAP_ADDR), .MAP_DATA(MAP_DATA));

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: host queue, clear progress index, round-robin memory.
  logic [15:0] q[$];
  bit          m_clr, m_last_eng, m_gnt, m_we, m_ovf, eng_taken;
  int          m_idx, m_drop;
  logic [7:0]  m_fill, m_addr, m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_edge();
    bit was_gnt, hv, ev, drop;
    logic [15:0] e;
    if (RESET) begin
      q.delete(); m_clr = 0; m_idx = 0; m_fill = 0; m_last_eng = 1; m_gnt = 0;
      m_we = 0; m_addr = 0; m_data = 0; m_ovf = 0; m_drop = 0;
      return;
    end
    was_gnt = m_gnt; m_we = 0; m_gnt = 0;
    if (m_clr) begin
      m_we = 1; m_addr = 8'(m_idx); m_data = m_fill;
      m_idx++;
      if (m_idx == MAP_SIZE) m_clr = 0;
    end else if (CLR_START) begin
      m_clr = 1; m_idx = 0; m_fill = CLR_DATA;
    end else begin
      hv = (q.size() > 0);
      ev = ENG_REQ && !was_gnt;
      if (hv && (!ev || m_last_eng)) begin
        e = q.pop_front();
        m_addr = e[15:8]; m_data = e[7:0]; m_we = 1; m_last_eng = 0;
      end else if (ev) begin
        m_addr = ENG_ADDR; m_data = ENG_DATA; m_we = 1; m_gnt = 1; m_last_eng = 1; eng_taken = 1;
      end
    end
    drop = 0;
    if (HOST_WE) begin
      if (q.size() < DEPTH) q.push_back({HOST_ADDR, HOST_DATA});
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (OVF_CLR) m_ovf = 0;
    if (STATS != 0) begin
      if (OVF_CLR) m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 65535) m_drop++;
    end
  endfunction

  task automatic check_outputs();
    chk("gnt",   32'(ENG_GNT),    32'(m_gnt));
    chk("busy",  32'(CLR_BUSY),   32'(m_clr));
    chk("ovf",   32'(HOST_OVF),   32'(m_ovf));
    chk("level", 32'(FIFO_LEVEL), q.size());
    chk("drop",  32'(DROP_CNT),   m_drop);
    chk("we",    32'(MAP_WE),     32'(m_we));
    chk("addr",  32'(MAP_ADDR),   32'(m_addr));
    chk("data",  32'(MAP_DATA),   32'(m_data));
  endtask

  // One clock: model and DUT see the same inputs, outputs checked 1ns later.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
    HOST_WE = 0; CLR_START = 0; OVF_CLR = 0; RESET = 0;
  endtask

  task automatic do_reset();
    RESET = 1; tick();
  endtask

  task automatic host(input logic [7:0] a, input logic [7:0] d);
    HOST_WE = 1; HOST_ADDR = a; HOST_DATA = d;
  endtask

  initial begin
    int busy_n, sweep_a;
    RESET = 1; HOST_WE = 0; ENG_REQ = 0; CLR_START = 0; OVF_CLR = 0;
    HOST_ADDR = 0; HOST_DATA = 0; ENG_ADDR = 0; ENG_DATA = 0; CLR_DATA = 0;
    eng_taken = 0;
    tick(); do_reset();
    chk("rst_we", 32'(MAP_WE), 0);
    chk("rst_level", 32'(FIFO_LEVEL), 0);

    // Single host write: visible the cycle after the following edge.
    host(8'h12, 8'h34); tick();
    tick();
    chk("t1_we", 32'(MAP_WE), 1);
    chk("t1_addr", 32'(MAP_ADDR), 32'h12);
    chk("t1_data", 32'(MAP_DATA), 32'h34);
    chk("t1_level", 32'(FIFO_LEVEL), 0);

    // Full sweep: repeat start ignored, host/engine queued mid-sweep come after.
    do_reset();
    CLR_DATA = 8'hAA; CLR_START = 1; tick();
    busy_n = 0; sweep_a = 0;
    for (int t = 0; t <= 256; t++) begin
      if (CLR_BUSY) busy_n++;
      if (MAP_WE && MAP_DATA == 8'hAA && int'(MAP_ADDR) == sweep_a) sweep_a++;
      if (t == 50)  begin CLR_START = 1; CLR_DATA = 8'h55; end
      if (t == 100) host(8'h21, 8'h01);
      if (t == 101) host(8'h22, 8'h02);
      if (t == 200) begin ENG_REQ = 1; ENG_ADDR = 8'h80; ENG_DATA = 8'h55; end
      tick();
    end
    chk("t4_busy_cycles", busy_n, 256);
    chk("t4_sweep_writes", sweep_a, 256);
    chk("t2_h1_addr", 32'(MAP_ADDR), 32'h21);
    chk("t2_h1_gnt", 32'(ENG_GNT), 0);
    tick();
    chk("t2_eng_gnt", 32'(ENG_GNT), 1);
    chk("t2_eng_addr", 32'(MAP_ADDR), 32'h80);
    tick();
    ENG_REQ = 0;
    chk("t2_h2_addr", 32'(MAP_ADDR), 32'h22);
    chk("t2_h2_gnt", 32'(ENG_GNT), 0);
    tick();

    // Overflow during a clear, then push on the first pop edge after it.
    do_reset();
    CLR_DATA = 8'h00; CLR_START = 1; tick();
    for (int t = 0; t <= 256; t++) begin
      if (t < 5) host(8'(8'h40 + t), 8'(t));
      if (t == 10) begin
        chk("t3_level", 32'(FIFO_LEVEL), 4);
        chk("t3_ovf", 32'(HOST_OVF), 1);
        chk("t3_drop", 32'(DROP_CNT), STATS);
        OVF_CLR = 1;
      end
      if (t == 11) begin
        chk("t3_ovf_clr", 32'(HOST_OVF), 0);
        chk("t3_drop_clr", 32'(DROP_CNT), 0);
      end
      if (t == 256) host(8'h77, 8'h07);
      tick();
    end
    chk("t6_level", 32'(FIFO_LEVEL), 4);
    chk("t6_ovf", 32'(HOST_OVF), 0);
    chk("t6_addr", 32'(MAP_ADDR), 32'h40);

    // Reset in the middle of a sweep with writes queued.
    do_reset();
    CLR_DATA = 8'h3C; CLR_START = 1; tick();
    for (int t = 0; t <= 100; t++) begin
      if (t < 2) host(8'(8'h90 + t), 8'hEE);
      tick();
    end
    chk("t5_at100", 32'(MAP_ADDR), 100);
    RESET = 1; tick();
    chk("t5_we", 32'(MAP_WE), 0);
    chk("t5_busy", 32'(CLR_BUSY), 0);
    chk("t5_level", 32'(FIFO_LEVEL), 0);
    chk("t5_addr", 32'(MAP_ADDR), 0);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t5_idle_we", 32'(MAP_WE), 0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) < 4) host(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 399) == 0) begin CLR_START = 1; CLR_DATA = 8'($urandom); end
      if ($urandom_range(0, 19) == 0) OVF_CLR = 1;
      if ($urandom_range(0, 1499) == 0) RESET = 1;
      if (!m_gnt && (!ENG_REQ || eng_taken)) begin
        ENG_REQ = ($urandom_range(0, 2) != 0);
        ENG_ADDR = 8'($urandom); ENG_DATA = 8'($urandom);
        eng_taken = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
